// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_ADDR_WIDTH  = 5;
    localparam int unsigned DEF_DATA_WIDTH  = 32;

    // Widest register the merge helper handles; callers zero-extend and truncate.
    localparam int unsigned MERGE_MAX_WIDTH = 512;
    localparam int unsigned MERGE_MAX_BYTES = MERGE_MAX_WIDTH / 8;

    // Byte b of the result is new_data byte b when strobes[b] is set, else old_data byte b.
    function automatic logic [MERGE_MAX_WIDTH-1:0] byte_merge(
        input logic [MERGE_MAX_WIDTH-1:0] old_data,
        input logic [MERGE_MAX_WIDTH-1:0] new_data,
        input logic [MERGE_MAX_BYTES-1:0] strobes
    );
        logic [MERGE_MAX_WIDTH-1:0] merged;
        merged = old_data;
        for (int unsigned b = 0; b < MERGE_MAX_BYTES; b++) begin
            if (strobes[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Signed change of the pending population for one cycle: +1 per rise, -1 per fall.
    function automatic int pend_delta(input logic rise, input logic fall);
        int delta;
        delta = 0;
        if (rise) begin
            delta = delta + 1;
        end
        if (fall) begin
            delta = delta - 1;
        end
        return delta;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: decode, write bypass, byte merge and validity.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BYPASS     = 1
) (
    input  logic [ADDR_WIDTH-1:0]     a_rd,
    input  logic [DATA_WIDTH-1:0]     regs [2**ADDR_WIDTH],
    input  logic [2**ADDR_WIDTH-1:0]  pend,
    input  logic                      we3,
    input  logic [ADDR_WIDTH-1:0]     a3,
    input  logic [DATA_WIDTH-1:0]     wd3,
    input  logic [DATA_WIDTH/8-1:0]   be3,
    output logic [DATA_WIDTH-1:0]     rd,
    output logic                      rd_valid
);

    logic                  is_zero;
    logic                  fwd;
    logic [DATA_WIDTH-1:0] stored;
    logic [DATA_WIDTH-1:0] merged;

    // Select stored data, forward a same-cycle write when enabled, and qualify with pend.
    always_comb begin
        is_zero  = (a_rd == '0);
        fwd      = (BYPASS != 0) && we3 && (a3 == a_rd) && !is_zero;
        stored   = regs[a_rd];
        merged   = DATA_WIDTH'(byte_merge(MERGE_MAX_WIDTH'(stored),
                                          MERGE_MAX_WIDTH'(wd3),
                                          MERGE_MAX_BYTES'(be3)));
        rd       = stored;
        if (is_zero) begin
            rd = '0;
        end else if (fwd) begin
            rd = merged;
        end
        rd_valid = is_zero || !pend[a_rd] || fwd;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with byte-strobed writes, write bypass and a
// per-register pending scoreboard for long-latency producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   A_RD,
    output logic [NUM_RD*DATA_WIDTH-1:0]   RD,
    output logic [NUM_RD-1:0]              RD_VALID,
    input  logic [ADDR_WIDTH-1:0]          A3,
    input  logic [DATA_WIDTH-1:0]          WD3,
    input  logic                           WE3,
    input  logic [DATA_WIDTH/8-1:0]        BE3,
    input  logic                           ISSUE_EN,
    input  logic [ADDR_WIDTH-1:0]          ISSUE_A,
    output logic [ADDR_WIDTH:0]            PEND_CNT
);

    localparam int unsigned DEPTH     = 2**ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("regfile_scoreboard: NUM_RD must be 1..4");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH > MERGE_MAX_WIDTH) begin : g_bad_data_width
        $error("regfile_scoreboard: DATA_WIDTH must be a multiple of 8 within merge range");
    end

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pend;
    logic [CNT_WIDTH-1:0]  pend_cnt;

    logic                  wr_en;
    logic                  iss_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  pend_rise;
    logic                  pend_fall;

    // Qualify write/issue (x0 is inert) and classify pend transitions for the counter.
    always_comb begin
        wr_en     = WE3 && (A3 != '0);
        iss_en    = ISSUE_EN && (ISSUE_A != '0);
        wr_data   = DATA_WIDTH'(byte_merge(MERGE_MAX_WIDTH'(regs[A3]),
                                           MERGE_MAX_WIDTH'(WD3),
                                           MERGE_MAX_BYTES'(BE3)));
        pend_rise = iss_en && !pend[ISSUE_A];
        // A write to a register being re-issued in the same cycle leaves it pending.
        pend_fall = wr_en && pend[A3] && !(iss_en && (ISSUE_A == A3));
    end

    // Storage, pend bits and pending count; an issue overrides a same-register clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            regs     <= '{default: '0};
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_en) begin
                regs[A3] <= wr_data;
                pend[A3] <= 1'b0;
            end
            if (iss_en) begin
                pend[ISSUE_A] <= 1'b1;
            end
            pend_cnt <= pend_cnt + CNT_WIDTH'(pend_delta(pend_rise, pend_fall));
        end
    end

    assign PEND_CNT = pend_cnt;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .BYPASS     (BYPASS)
        ) u_read_port (
            .a_rd     (A_RD[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .regs     (regs),
            .pend     (pend),
            .we3      (WE3),
            .a3       (A3),
            .wd3      (WD3),
            .be3      (BE3),
            .rd       (RD[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd_valid (RD_VALID[i])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard with a word/flag-array reference model.
module tb_regfile_scoreboard;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 32;

    logic               CLK;
    logic               RST_N;
    logic [NR*AW-1:0]   A_RD;
    logic [NR*DW-1:0]   RD;
    logic [NR-1:0]      RD_VALID;
    logic [AW-1:0]      A3;
    logic [DW-1:0]      WD3;
    logic               WE3;
    logic [NB-1:0]      BE3;
    logic               ISSUE_EN;
    logic [AW-1:0]      ISSUE_A;
    logic [AW:0]        PEND_CNT;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_pend [DEPTH];

    regfile_scoreboard #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_RD     (NR),
        .BYPASS     (1)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .A_RD     (A_RD),
        .RD       (RD),
        .RD_VALID (RD_VALID),
        .A3       (A3),
        .WD3      (WD3),
        .WE3      (WE3),
        .BE3      (BE3),
        .ISSUE_EN (ISSUE_EN),
        .ISSUE_A  (ISSUE_A),
        .PEND_CNT (PEND_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [NB-1:0] be);
        logic [DW-1:0] mask;
        mask = '0;
        for (int b = 0; b < NB; b++) if (be[b]) mask = mask | (DW'(8'hFF) << (8 * b));
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int a);
        if (a == 0) return '0;
        if (WE3 && int'(A3) == a) return merge_bytes(m_reg[a], WD3, BE3);
        return m_reg[a];
    endfunction

    function automatic logic exp_valid(input int a);
        return (a == 0) || !m_pend[a] || (WE3 && int'(A3) == a);
    endfunction

    function automatic int exp_cnt();
        int n = 0;
        for (int r = 0; r < DEPTH; r++) if (m_pend[r]) n++;
        return n;
    endfunction

    // Advance one edge and apply the same edge to the model.
    task automatic tick();
        @(posedge CLK);
        if (!RST_N) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_reg[r]  = '0;
                m_pend[r] = 1'b0;
            end
        end else begin
            if (WE3 && A3 != 0) begin
                m_reg[A3]  = merge_bytes(m_reg[A3], WD3, BE3);
                m_pend[A3] = 1'b0;
            end
            if (ISSUE_EN && ISSUE_A != 0) m_pend[ISSUE_A] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        WE3      = 1'b0;
        A3       = '0;
        WD3      = '0;
        BE3      = '0;
        ISSUE_EN = 1'b0;
        ISSUE_A  = '0;
    endtask

    task automatic set_ports(input int a0, input int a1);
        A_RD = {AW'(a1), AW'(a0)};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N = 1'b0;
        idle();
        set_ports(0, 0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            set_ports(a, DEPTH - 1 - a);
            @(negedge CLK);
            checks++;
            if (RD !== '0) begin
                errors++;
                $display("FAIL reset_rd a=%0d: got %h expected 0", a, RD);
            end
            checks++;
            if (RD_VALID !== 2'b11) begin
                errors++;
                $display("FAIL reset_valid a=%0d: got %b expected 11", a, RD_VALID);
            end
            tick();
        end
        checks++;
        if (PEND_CNT !== 6'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d expected 0", PEND_CNT);
        end
    endtask

    task automatic test_byte_write();
        set_ports(5, 5);
        WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF; BE3 = 4'hF;
        @(negedge CLK);
        checks++;
        if (RD[0 +: DW] !== 32'hDEADBEEF || RD_VALID[0] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_full: got %h/%b expected deadbeef/1", RD[0 +: DW], RD_VALID[0]);
        end
        tick();
        WD3 = 32'h0000AA00; BE3 = 4'b0010;
        @(negedge CLK);
        checks++;
        if (RD[DW +: DW] !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL bypass_merge: got %h expected deadaaef", RD[DW +: DW]);
        end
        tick();
        idle();
        @(negedge CLK);
        checks++;
        if (RD[0 +: DW] !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL stored_merge: got %h expected deadaaef", RD[0 +: DW]);
        end
        tick();
        WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hFFFFFFFF; BE3 = 4'h0;
        @(negedge CLK);
        checks++;
        if (RD[0 +: DW] !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL bypass_be0: got %h expected deadaaef", RD[0 +: DW]);
        end
        tick();
        idle();
        @(negedge CLK);
        checks++;
        if (RD[0 +: DW] !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL stored_be0: got %h expected deadaaef", RD[0 +: DW]);
        end
        tick();
    endtask

    task automatic test_reg0();
        set_ports(0, 0);
        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'h00001234; BE3 = 4'hF;
        ISSUE_EN = 1'b1; ISSUE_A = 5'd0;
        @(negedge CLK);
        checks++;
        if (RD !== '0 || RD_VALID !== 2'b11) begin
            errors++;
            $display("FAIL x0_same_cycle: got %h/%b expected 0/11", RD, RD_VALID);
        end
        tick();
        idle();
        @(negedge CLK);
        checks++;
        if (RD !== '0 || RD_VALID !== 2'b11) begin
            errors++;
            $display("FAIL x0_after: got %h/%b expected 0/11", RD, RD_VALID);
        end
        checks++;
        if (PEND_CNT !== 6'd0) begin
            errors++;
            $display("FAIL x0_cnt: got %0d expected 0", PEND_CNT);
        end
        tick();
    endtask

    task automatic test_pending();
        ISSUE_EN = 1'b1; ISSUE_A = 5'd3;
        tick();
        ISSUE_A = 5'd7;
        tick();
        idle();
        set_ports(3, 7);
        @(negedge CLK);
        checks++;
        if (PEND_CNT !== 6'd2) begin
            errors++;
            $display("FAIL pend_two: got %0d expected 2", PEND_CNT);
        end
        checks++;
        if (RD_VALID !== 2'b00) begin
            errors++;
            $display("FAIL pend_invalid: got %b expected 00", RD_VALID);
        end
        tick();
        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'hCAFE0003; BE3 = 4'hF;
        @(negedge CLK);
        checks++;
        if (RD_VALID !== 2'b01 || RD[0 +: DW] !== 32'hCAFE0003) begin
            errors++;
            $display("FAIL pend_bypass: got %b/%h expected 01/cafe0003", RD_VALID, RD[0 +: DW]);
        end
        tick();
        idle();
        @(negedge CLK);
        checks++;
        if (PEND_CNT !== 6'd1 || RD_VALID !== 2'b01) begin
            errors++;
            $display("FAIL pend_clear: got %0d/%b expected 1/01", PEND_CNT, RD_VALID);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        set_ports(9, 9);
        ISSUE_EN = 1'b1; ISSUE_A = 5'd9;
        WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h00000055; BE3 = 4'hF;
        @(negedge CLK);
        checks++;
        if (RD[0 +: DW] !== 32'h00000055 || RD_VALID[0] !== 1'b1) begin
            errors++;
            $display("FAIL waw_bypass: got %h/%b expected 00000055/1", RD[0 +: DW], RD_VALID[0]);
        end
        tick();
        idle();
        @(negedge CLK);
        checks++;
        if (PEND_CNT !== 6'd2 || RD[0 +: DW] !== 32'h00000055 || RD_VALID[0] !== 1'b0) begin
            errors++;
            $display("FAIL waw_after: got %0d/%h/%b expected 2/00000055/0",
                     PEND_CNT, RD[0 +: DW], RD_VALID[0]);
        end
        tick();
        set_ports(7, 10);
        ISSUE_EN = 1'b1; ISSUE_A = 5'd10;
        WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h00000077; BE3 = 4'b0001;
        @(negedge CLK);
        checks++;
        if (RD_VALID !== 2'b11) begin
            errors++;
            $display("FAIL swap_during: got %b expected 11", RD_VALID);
        end
        tick();
        idle();
        @(negedge CLK);
        checks++;
        if (PEND_CNT !== 6'd2 || RD_VALID !== 2'b01 || RD[0 +: DW] !== 32'h00000077) begin
            errors++;
            $display("FAIL swap_after: got %0d/%b/%h expected 2/01/00000077",
                     PEND_CNT, RD_VALID, RD[0 +: DW]);
        end
        tick();
    endtask

    task automatic test_fill();
        for (int a = 1; a < DEPTH; a++) begin
            ISSUE_EN = 1'b1; ISSUE_A = AW'(a);
            tick();
        end
        ISSUE_A = 5'd5;
        @(negedge CLK);
        checks++;
        if (PEND_CNT !== 6'd31) begin
            errors++;
            $display("FAIL fill_max: got %0d expected 31", PEND_CNT);
        end
        tick();
        idle();
        set_ports(31, 0);
        @(negedge CLK);
        checks++;
        if (PEND_CNT !== 6'd31 || RD_VALID !== 2'b10) begin
            errors++;
            $display("FAIL fill_hold: got %0d/%b expected 31/10", PEND_CNT, RD_VALID);
        end
        for (int a = 1; a < DEPTH; a++) begin
            WE3 = 1'b1; A3 = AW'(a); WD3 = $urandom; BE3 = '0;
            tick();
        end
        idle();
        set_ports(5, 31);
        @(negedge CLK);
        checks++;
        if (PEND_CNT !== 6'd0 || RD_VALID !== 2'b11 || RD[0 +: DW] !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL drain: got %0d/%b/%h expected 0/11/deadaaef",
                     PEND_CNT, RD_VALID, RD[0 +: DW]);
        end
        tick();
    endtask

    task automatic test_reset_override();
        ISSUE_EN = 1'b1; ISSUE_A = 5'd13;
        tick();
        RST_N = 1'b0;
        WE3 = 1'b1; A3 = 5'd12; WD3 = 32'hFFFFFFFF; BE3 = 4'hF;
        ISSUE_EN = 1'b1; ISSUE_A = 5'd14;
        tick();
        RST_N = 1'b1;
        idle();
        set_ports(12, 13);
        @(negedge CLK);
        checks++;
        if (PEND_CNT !== 6'd0 || RD !== '0 || RD_VALID !== 2'b11) begin
            errors++;
            $display("FAIL rst_override: got %0d/%h/%b expected 0/0/11", PEND_CNT, RD, RD_VALID);
        end
        set_ports(5, 14);
        #1;
        checks++;
        if (RD !== '0 || RD_VALID !== 2'b11) begin
            errors++;
            $display("FAIL rst_cleared: got %h/%b expected 0/11", RD, RD_VALID);
        end
        WE3 = 1'b1; A3 = 5'd12; WD3 = 32'hA5A5A5A5; BE3 = 4'hF;
        ISSUE_EN = 1'b1; ISSUE_A = 5'd13;
        tick();
        idle();
        set_ports(12, 13);
        @(negedge CLK);
        checks++;
        if (RD[0 +: DW] !== 32'hA5A5A5A5 || RD_VALID !== 2'b01 || PEND_CNT !== 6'd1) begin
            errors++;
            $display("FAIL rst_release: got %h/%b/%0d expected a5a5a5a5/01/1",
                     RD[0 +: DW], RD_VALID, PEND_CNT);
        end
        tick();
    endtask

    task automatic test_random();
        int addr [NR];
        for (int n = 0; n < 600; n++) begin
            RST_N    = ($urandom_range(0, 59) != 0);
            WE3      = ($urandom_range(0, 1) != 0);
            A3       = AW'($urandom_range(0, DEPTH - 1));
            WD3      = $urandom;
            BE3      = NB'($urandom_range(0, 15));
            ISSUE_EN = ($urandom_range(0, 2) == 0);
            ISSUE_A  = AW'($urandom_range(0, DEPTH - 1));
            for (int p = 0; p < NR; p++) begin
                addr[p] = ($urandom_range(0, 2) == 0) ? int'(A3) : int'($urandom_range(0, DEPTH - 1));
            end
            set_ports(addr[0], addr[1]);
            @(negedge CLK);
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (RD[p*DW +: DW] !== exp_rd(addr[p]) || RD_VALID[p] !== exp_valid(addr[p])) begin
                    errors++;
                    $display("FAIL rand_read n=%0d p=%0d a=%0d: got %h/%b expected %h/%b",
                             n, p, addr[p], RD[p*DW +: DW], RD_VALID[p],
                             exp_rd(addr[p]), exp_valid(addr[p]));
                end
            end
            checks++;
            if (int'(PEND_CNT) != exp_cnt()) begin
                errors++;
                $display("FAIL rand_cnt n=%0d: got %0d expected %0d", n, PEND_CNT, exp_cnt());
            end
            tick();
        end
        RST_N = 1'b1;
        idle();
    endtask

    initial begin
        RST_N = 1'b0;
        idle();
        set_ports(0, 0);
        test_reset();
        test_byte_write();
        test_reg0();
        test_pending();
        test_same_cycle();
        test_fill();
        test_reset_override();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
